// File: rtl/i2c_pkg.sv
// Shared I2C definitions: target FSM states,
// transfer direction codes and fill byte.
package i2c_pkg;

  typedef enum logic [8:0] {
    S_IDLE      = 9'h001,
    S_ADDR      = 9'h002,
    S_ADDR_ACK  = 9'h004,
    S_RX_BYTE   = 9'h008,
    S_RX_ACK    = 9'h010,
    S_TX_LOAD   = 9'h020,
    S_TX_BYTE   = 9'h040,
    S_TX_ACK    = 9'h080,
    S_WAIT_STOP = 9'h100
  } slv_state_e;

  localparam logic I2C_write_operation = 1'b0;
  localparam logic I2C_read_operation  = 1'b1;
  localparam logic [7:0] NACK_FILL_BYTE = 8'hFF;

endpackage

// File: rtl/i2c_slave_ctrl_if.sv
// Bus pins and host byte interface of
// the I2C target controller.
interface i2c_slave_ctrl_if;
  import i2c_pkg::*;

  logic       EN;
  logic [6:0] OWN_ADDR;
  logic       SCL_in;
  logic       SDA_in;
  logic       SDA_oe;
  logic [7:0] RX_DATA;
  logic       RX_VALID;
  logic       RX_READY;
  logic [7:0] TX_DATA;
  logic       TX_VALID;
  logic       TX_REQ;
  logic       TX_UNDERRUN;
  logic       ADDR_MATCH;
  logic       RW;
  logic       BUSY;
  logic       STOP_DET;

  modport slave (
    input  EN, OWN_ADDR, SCL_in, SDA_in,
    input  RX_READY, TX_DATA, TX_VALID,
    output SDA_oe, RX_DATA, RX_VALID,
    output TX_REQ, TX_UNDERRUN, ADDR_MATCH,
    output RW, BUSY, STOP_DET
  );

  modport master (
    output EN, OWN_ADDR, SCL_in, SDA_in,
    output RX_READY, TX_DATA, TX_VALID,
    input  SDA_oe, RX_DATA, RX_VALID,
    input  TX_REQ, TX_UNDERRUN, ADDR_MATCH,
    input  RW, BUSY, STOP_DET
  );

endinterface

// File: rtl/i2c_bus_monitor.sv
// SCL/SDA synchronizers with edge, START
// and STOP detection; shared with the master.
module i2c_bus_monitor #(
  parameter int SYNC_STAGES = 2
) (
  input  logic CLK,
  input  logic RST,
  input  logic scl,
  input  logic sda,
  output logic scl_rise,
  output logic scl_fall,
  output logic sda_lvl,
  output logic start,
  output logic stop
);

  logic [SYNC_STAGES-1:0] scl_sync;
  logic [SYNC_STAGES-1:0] sda_sync;
  logic scl_q;
  logic sda_q;
  logic scl_lvl;
  logic sda_rise;
  logic sda_fall;

  // Reset to the idle-bus level so release
  // from reset never looks like an edge.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      scl_sync <= '1;
      sda_sync <= '1;
      scl_q    <= 1'b1;
      sda_q    <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl};
      sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda};
      scl_q    <= scl_lvl;
      sda_q    <= sda_lvl;
    end
  end

  assign scl_lvl  = scl_sync[SYNC_STAGES-1];
  assign sda_lvl  = sda_sync[SYNC_STAGES-1];
  assign scl_rise = scl_lvl & ~scl_q;
  assign scl_fall = ~scl_lvl & scl_q;
  assign sda_rise = sda_lvl & ~sda_q;
  assign sda_fall = ~sda_lvl & sda_q;
  assign start    = sda_fall & scl_lvl & scl_q;
  assign stop     = sda_rise & scl_lvl & scl_q;

endmodule

// File: rtl/i2c_slave_ctrl.sv
// I2C target controller: address match, write
// byte receive and read byte transmit, no stretching.
module i2c_slave_ctrl
  import i2c_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input logic           CLK,
  input logic           RST,
  i2c_slave_ctrl_if.slave bus
);

  logic scl_rise, scl_fall, sda, start, stop;

  i2c_bus_monitor #(.SYNC_STAGES(SYNC_STAGES)) u_mon (
    .CLK      (CLK),
    .RST      (RST),
    .scl      (bus.SCL_in),
    .sda      (bus.SDA_in),
    .scl_rise (scl_rise),
    .scl_fall (scl_fall),
    .sda_lvl  (sda),
    .start    (start),
    .stop     (stop)
  );

  slv_state_e state, state_n;
  logic [2:0] cnt, cnt_n;
  logic [6:0] sh, sh_n;
  logic [7:0] rx, rx_n, byte_in, tx_byte;
  logic oe, oe_n, rw, rw_n, busy, busy_n;
  logic rxv, rxv_n, txr, txr_n, txu, txu_n;
  logic am, am_n, sd, sd_n;

  assign byte_in = {sh, sda};
  assign tx_byte = bus.TX_VALID ? bus.TX_DATA
                                : NACK_FILL_BYTE;

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    sh_n    = sh;
    rx_n    = rx;
    oe_n    = oe;
    rw_n    = rw;
    busy_n  = busy;
    rxv_n   = 1'b0;
    txr_n   = 1'b0;
    txu_n   = 1'b0;
    am_n    = 1'b0;
    sd_n    = 1'b0;
    if (start) begin
      state_n = S_ADDR;
      cnt_n   = 3'd0;
      oe_n    = 1'b0;
      busy_n  = 1'b1;
    end else if (stop) begin
      state_n = S_IDLE;
      oe_n    = 1'b0;
      busy_n  = 1'b0;
      sd_n    = 1'b1;
    end else begin
      unique case (state)
        S_ADDR: if (scl_rise) begin
          sh_n  = byte_in[6:0];
          cnt_n = cnt + 3'd1;
          if (cnt == 3'd7) begin
            rw_n = byte_in[0];
            if (byte_in[7:1] == bus.OWN_ADDR
                && |byte_in[7:1]) begin
              am_n    = 1'b1;
              state_n = S_ADDR_ACK;
            end else begin
              state_n = S_WAIT_STOP;
            end
          end
        end
        // oe doubles as the "ACK already driven" phase flag
        S_ADDR_ACK: if (scl_fall) begin
          if (!oe) begin
            oe_n = 1'b1;
          end else if (rw == I2C_read_operation) begin
            oe_n    = 1'b0;
            txr_n   = 1'b1;
            state_n = S_TX_LOAD;
          end else begin
            oe_n    = 1'b0;
            cnt_n   = 3'd0;
            state_n = S_RX_BYTE;
          end
        end
        S_RX_BYTE: if (scl_rise) begin
          sh_n  = byte_in[6:0];
          cnt_n = cnt + 3'd1;
          if (cnt == 3'd7) begin
            rx_n    = byte_in;
            state_n = S_RX_ACK;
          end
        end
        S_RX_ACK: if (scl_fall) begin
          if (oe) begin
            oe_n    = 1'b0;
            state_n = S_RX_BYTE;
          end else if (bus.RX_READY) begin
            rxv_n = 1'b1;
            oe_n  = 1'b1;
          end else begin
            state_n = S_WAIT_STOP;
          end
        end
        // First cycle carries TX_REQ, second latches the byte
        S_TX_LOAD: if (!txr) begin
          sh_n    = tx_byte[6:0];
          oe_n    = ~tx_byte[7];
          txu_n   = ~bus.TX_VALID;
          cnt_n   = 3'd0;
          state_n = S_TX_BYTE;
        end
        S_TX_BYTE: if (scl_fall) begin
          if (cnt == 3'd7) begin
            oe_n    = 1'b0;
            state_n = S_TX_ACK;
          end else begin
            oe_n  = ~sh[6];
            sh_n  = {sh[5:0], 1'b0};
            cnt_n = cnt + 3'd1;
          end
        end
        S_TX_ACK: begin
          if (scl_rise && sda) begin
            state_n = S_WAIT_STOP;
          end else if (scl_fall) begin
            txr_n   = 1'b1;
            state_n = S_TX_LOAD;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state <= S_IDLE;
      cnt   <= '0;
      sh    <= '0;
      rx    <= '0;
      oe    <= 1'b0;
      rw    <= 1'b0;
      busy  <= 1'b0;
      rxv   <= 1'b0;
      txr   <= 1'b0;
      txu   <= 1'b0;
      am    <= 1'b0;
      sd    <= 1'b0;
    end else if (!bus.EN) begin
      state <= S_IDLE;
      cnt   <= '0;
      sh    <= '0;
      rx    <= '0;
      oe    <= 1'b0;
      rw    <= 1'b0;
      busy  <= 1'b0;
      rxv   <= 1'b0;
      txr   <= 1'b0;
      txu   <= 1'b0;
      am    <= 1'b0;
      sd    <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      sh    <= sh_n;
      rx    <= rx_n;
      oe    <= oe_n;
      rw    <= rw_n;
      busy  <= busy_n;
      rxv   <= rxv_n;
      txr   <= txr_n;
      txu   <= txu_n;
      am    <= am_n;
      sd    <= sd_n;
    end
  end

  assign bus.SDA_oe      = oe;
  assign bus.RX_DATA     = rx;
  assign bus.RX_VALID    = rxv;
  assign bus.TX_REQ      = txr;
  assign bus.TX_UNDERRUN = txu;
  assign bus.ADDR_MATCH  = am;
  assign bus.RW          = rw;
  assign bus.BUSY        = busy;
  assign bus.STOP_DET    = sd;

endmodule
